// File: rtl/waterfall_line_ram_if.sv
// rtl/waterfall_line_ram_if.sv - write, commit, read and status signals of the waterfall line store
// master drives writes/commits/reads; slave is the line store itself.
interface waterfall_line_ram_if #(
  parameter int BINS_W  = 5,
  parameter int LINES_W = 4,
  parameter int DATA_W  = 8
);
  logic                w_en;
  logic [BINS_W-1:0]   w_bin;
  logic [DATA_W-1:0]   d_in;
  logic                w_commit;
  logic                r_en;
  logic [LINES_W-1:0]  r_age;
  logic [BINS_W-1:0]   r_bin;
  logic [DATA_W-1:0]   d_out;
  logic                d_valid;
  logic                busy;
  logic [LINES_W-1:0]  head;
  logic [LINES_W:0]    lines_filled;

  modport master (
    output w_en, w_bin, d_in, w_commit, r_en, r_age, r_bin,
    input  d_out, d_valid, busy, head, lines_filled
  );

  modport slave (
    input  w_en, w_bin, d_in, w_commit, r_en, r_age, r_bin,
    output d_out, d_valid, busy, head, lines_filled
  );
endinterface

// File: rtl/waterfall_line_ram.sv
// rtl/waterfall_line_ram.sv - circular multi-line bin store, read by line age, self-clearing after reset
// Optional macro LINE_CLEAR_EN: zero the new head line after every commit.
module waterfall_line_ram #(
  parameter int BINS_W  = 5,
  parameter int LINES_W = 4,
  parameter int DATA_W  = 8
) (
  input logic clk,
  input logic reset,
  waterfall_line_ram_if.slave bus
);
  localparam int ADDR_W = BINS_W + LINES_W;
  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
`ifdef LINE_CLEAR_EN
  localparam logic [1:0] ST_LCLR  = 2'd2;
`endif
  localparam logic [LINES_W:0] FULL = {1'b1, {LINES_W{1'b0}}};

  logic [1:0]         state;
  logic [ADDR_W-1:0]  cnt;
  logic [LINES_W-1:0] head_q;
  logic [LINES_W:0]   filled_q;
  logic [DATA_W-1:0]  d_out_q;
  logic               d_valid_q;

  logic [DATA_W-1:0]  mem [0:(1<<ADDR_W)-1];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  logic               run;
  logic [LINES_W-1:0] rd_line;
  logic               age_ok;

  assign run     = (state == ST_RUN);
  // Age is resolved against the head before any same-cycle commit.
  assign rd_line = head_q - LINES_W'(1) - bus.r_age;
  assign age_ok  = ({1'b0, bus.r_age} < filled_q);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {head_q, bus.w_bin};
    mem_wdata = bus.d_in;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt;
        mem_wdata = '0;
      end
      ST_RUN: mem_we = bus.w_en;
`ifdef LINE_CLEAR_EN
      ST_LCLR: begin
        mem_we    = 1'b1;
        mem_addr  = {head_q, cnt[BINS_W-1:0]};
        mem_wdata = '0;
      end
`endif
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Non-blocking write means a same-address read sees the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
    end else begin
      d_valid_q <= run && bus.r_en;
      if (run && bus.r_en) d_out_q <= age_ok ? mem[{rd_line, bus.r_bin}] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_CLEAR;
      cnt      <= '0;
      head_q   <= '0;
      filled_q <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == '1) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          if (bus.w_commit) begin
            head_q <= head_q + LINES_W'(1);
            if (filled_q != FULL) filled_q <= filled_q + (LINES_W+1)'(1);
`ifdef LINE_CLEAR_EN
            state <= ST_LCLR;
            cnt   <= '0;
`endif
          end
        end
`ifdef LINE_CLEAR_EN
        ST_LCLR: begin
          if (cnt[BINS_W-1:0] == '1) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
`endif
        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.d_out        = d_out_q;
  assign bus.d_valid      = d_valid_q;
  assign bus.busy         = !run;
  assign bus.head         = head_q;
  assign bus.lines_filled = filled_q;
endmodule

// File: tb/tb_waterfall_line_ram.sv
// tb/tb_waterfall_line_ram.sv - randomized and directed bench for waterfall_line_ram against a line-history model
// Honours LINE_CLEAR_EN the same way as the design.
module tb_waterfall_line_ram;
  localparam int BW = 5;
  localparam int LW = 4;
  localparam int DW = 8;
  localparam int NB = 1 << BW;
  localparam int NL = 1 << LW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  waterfall_line_ram_if #(.BINS_W(BW), .LINES_W(LW), .DATA_W(DW)) bus ();
  waterfall_line_ram #(.BINS_W(BW), .LINES_W(LW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: committed lines newest-first; the open line reuses the slot of the line 16 commits back.
  logic [NB*DW-1:0] hist [$];
  logic [NB*DW-1:0] open_line;
  logic [LW-1:0]    m_head;
  int               m_filled;
  int               busy_left;
  logic [DW-1:0]    last_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int age, input int bin);
    if (age >= m_filled) return '0;
    if (age < hist.size()) return hist[age][bin*DW +: DW];
    return open_line[bin*DW +: DW];
  endfunction

  task automatic model_commit();
    logic [NB*DW-1:0] stale;
    hist.push_front(open_line);
    m_head = m_head + LW'(1);
    if (m_filled < NL) m_filled++;
    stale = '0;
    if (hist.size() > NL - 1) stale = hist.pop_back();
`ifdef LINE_CLEAR_EN
    open_line = '0;
    busy_left = NB;
`else
    open_line = stale;
`endif
  endtask

  task automatic step(input logic we, input logic [BW-1:0] wb, input logic [DW-1:0] di,
                      input logic wc, input logic re, input logic [LW-1:0] ra, input logic [BW-1:0] rb);
    logic exp_v;
    logic [DW-1:0] exp_d;
    logic act;
    check("busy", bus.busy, busy_left > 0);
    bus.w_en = we; bus.w_bin = wb; bus.d_in = di; bus.w_commit = wc;
    bus.r_en = re; bus.r_age = ra; bus.r_bin = rb;
    act   = (busy_left == 0);
    exp_v = act && re;
    exp_d = last_d;
    if (exp_v) exp_d = model_read(int'(ra), int'(rb));
    if (!act) busy_left--;
    if (act && we) open_line[int'(wb)*DW +: DW] = di;
    if (act && wc) model_commit();
    @(posedge clk);
    #1;
    check("d_valid", bus.d_valid, exp_v);
    check("d_out", bus.d_out, exp_d);
    check("head", bus.head, m_head);
    check("lines_filled", bus.lines_filled, m_filled);
    last_d = exp_d;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic settle();
    for (int i = 0; i < 64 && busy_left > 0; i++) idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.w_en = 1'b0; bus.w_commit = 1'b0; bus.r_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1);
    check("rst_head", bus.head, 0);
    check("rst_filled", bus.lines_filled, 0);
    check("rst_d_out", bus.d_out, 0);
    check("rst_d_valid", bus.d_valid, 0);
    reset = 1'b0;
    hist.delete();
    open_line = '0;
    m_head = '0;
    m_filled = 0;
    last_d = '0;
    busy_left = NL * NB;
  endtask

  task automatic sweep_phase(input string tag);
    int nb = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.busy) nb++;
      step(1'($urandom), BW'($urandom), DW'($urandom), 1'b0, 1'($urandom), LW'($urandom), BW'($urandom));
    end
    check(tag, nb, 512);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.w_en = 1'b0; bus.w_bin = '0; bus.d_in = '0; bus.w_commit = 1'b0;
    bus.r_en = 1'b0; bus.r_age = '0; bus.r_bin = '0;
    @(posedge clk);
    #1;
    do_reset();
    sweep_phase("sweep_after_reset");

    for (int b = 0; b < NB; b++) step(1'b1, BW'(b), DW'(b + 16), 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    settle();
    for (int b = 0; b < NB; b++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, '0, BW'(b));
      check("line_read", bus.d_out, b + 16);
    end
    check("one_line_head", bus.head, 1);
    check("one_line_filled", bus.lines_filled, 1);

    do_reset();
    sweep_phase("sweep_second");
    for (int k = 0; k < 20; k++) begin
      for (int b = 0; b < NB; b++) step(1'b1, BW'(b), DW'(k), 1'b0, 1'b0, '0, '0);
      step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
      settle();
    end
    check("wrap_head", bus.head, 4);
    check("wrap_filled", bus.lines_filled, 16);
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd0, 5'd9);
    check("age0_newest", bus.d_out, 19);
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd15, 5'd9);
`ifdef LINE_CLEAR_EN
    check("age15_head_line", bus.d_out, 0);
`else
    check("age15_head_line", bus.d_out, 4);
`endif

    step(1'b1, 5'd3, 8'hAA, 1'b1, 1'b0, '0, '0);
    settle();
    check("commit_head_inc", bus.head, 5);
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd0, 5'd3);
    check("write_with_commit", bus.d_out, 8'hAA);

    step(1'b1, 5'd7, 8'h05, 1'b0, 1'b0, '0, '0);
    step(1'b1, 5'd7, 8'h77, 1'b0, 1'b1, 4'd15, 5'd7);
    check("rbw_old", bus.d_out, 8'h05);
    step(1'b0, '0, '0, 1'b0, 1'b1, 4'd15, 5'd7);
    check("rbw_new", bus.d_out, 8'h77);

    for (int i = 0; i < 1500; i++)
      step(1'($urandom), BW'($urandom), DW'($urandom), ($urandom_range(11) == 0),
           1'($urandom), LW'($urandom), BW'($urandom));

    do_reset();
    sweep_phase("sweep_third");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, BW'($urandom), DW'($urandom), 1'b1, 1'b0, '0, '0);
      settle();
    end
    check("three_head", bus.head, 3);
    check("three_filled", bus.lines_filled, 3);
    do_reset();
    sweep_phase("sweep_mid_run");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
